memory_arbiter_2ch: RTL and testbench

MEMORY_ARBITER_2CH -- requirements
Module: memory_arbiter_2ch

---
 rtl/memory_arbiter_2ch_if.sv | 40 ++++
 rtl/memory_arbiter_2ch.sv | 92 +++++++++
 tb/tb_memory_arbiter_2ch.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_2ch_if.sv
// Bundle of the two requester channels and the memory port
// of the two-channel memory arbiter.
interface memory_arbiter_2ch_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  req0;
   logic                  req1;
   logic                  we0;
   logic                  we1;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  ack0;
   logic                  ack1;
   logic [DATA_WIDTH-1:0] rdata0;
   logic [DATA_WIDTH-1:0] rdata1;
   logic                  busy;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output req0, req1, we0, we1,
      output addr0, addr1, wdata0, wdata1,
      output mem_rdata,
      input  ack0, ack1, rdata0, rdata1, busy,
      input  mem_write, mem_addr, mem_wdata
   );

   modport slave (
      input  req0, req1, we0, we1,
      input  addr0, addr1, wdata0, wdata1,
      input  mem_rdata,
      output ack0, ack1, rdata0, rdata1, busy,
      output mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/memory_arbiter_2ch.sv
// Two-channel round-robin arbiter in front of a single-port
// memory; one transaction takes IDLE -> ACCESS -> DONE.
module memory_arbiter_2ch #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input logic                 clk,
   input logic                 rst,
   memory_arbiter_2ch_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  last_sel_q, last_sel_d;
   logic                  sel_q, sel_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
   logic                  grant1;

   always_comb begin
      state_d    = state_q;
      last_sel_d = last_sel_q;
      sel_d      = sel_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      // channel 1 wins alone, or on contention when 0 went last
      grant1     = bus.req1 & (~bus.req0 | ~last_sel_q);
      unique case (state_q)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               state_d    = ACCESS;
               sel_d      = grant1;
               last_sel_d = grant1;
               we_d       = grant1 ? bus.we1    : bus.we0;
               addr_d     = grant1 ? bus.addr1  : bus.addr0;
               wdata_d    = grant1 ? bus.wdata1 : bus.wdata0;
            end
         end
         ACCESS: state_d = DONE;
         DONE: begin
            state_d = IDLE;
            if (!we_q) begin
               if (sel_q) rdata1_d = bus.mem_rdata;
               else       rdata0_d = bus.mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_sel_q <= 1'b1;
         sel_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         last_sel_q <= last_sel_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   // rst masks the strobes so an aborted access has no effect
   assign bus.busy      = (state_q != IDLE);
   assign bus.mem_write = (state_q == ACCESS) & we_q & ~rst;
   assign bus.ack0      = (state_q == DONE) & ~sel_q & ~rst;
   assign bus.ack1      = (state_q == DONE) & sel_q & ~rst;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.rdata0    = rdata0_q;
   assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_memory_arbiter_2ch.sv
// Directed bench for memory_arbiter_2ch with a small
// registered-read memory model behind the arbiter.
module tb_memory_arbiter_2ch;
   localparam int AW = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   memory_arbiter_2ch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   memory_arbiter_2ch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // memory data appears the cycle after the address
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_mw", 32'(bus.mem_write), 0);
      chk("rst_ma", 32'(bus.mem_addr), 0);
      chk("rst_md", 32'(bus.mem_wdata), 0);
      chk("rst_ack", {30'd0, bus.ack1, bus.ack0}, 0);
      chk("rst_rd0", 32'(bus.rdata0), 0);
      chk("rst_rd1", 32'(bus.rdata1), 0);
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(8'h10 + i);
      bus.mem_rdata = '0;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0;
      bus.wdata0 = '0; bus.wdata1 = '0;
      tick();
      do_reset();

      // channel 0 write 0x22 to addr 3
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3; bus.wdata0 = 8'h22;
      tick();
      chk("w_mw", 32'(bus.mem_write), 1);
      chk("w_ma", 32'(bus.mem_addr), 3);
      chk("w_md", 32'(bus.mem_wdata), 32'h22);
      chk("w_busy", 32'(bus.busy), 1);
      chk("w_noack", 32'(bus.ack0), 0);
      tick();
      chk("w_ack0", 32'(bus.ack0), 1);
      chk("w_ack1", 32'(bus.ack1), 0);
      chk("w_mw_done", 32'(bus.mem_write), 0);
      bus.req0 = 0;
      tick();
      chk("w_ack_gone", 32'(bus.ack0), 0);
      chk("w_idle", 32'(bus.busy), 0);
      chk("w_rd0", 32'(bus.rdata0), 0);

      // channel 1 reads it back
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 3;
      tick();
      chk("r_mw", 32'(bus.mem_write), 0);
      chk("r_ma", 32'(bus.mem_addr), 3);
      tick();
      chk("r_ack1", 32'(bus.ack1), 1);
      chk("r_ack0", 32'(bus.ack0), 0);
      bus.req1 = 0;
      tick();
      chk("r_rd1", 32'(bus.rdata1), 32'h22);
      chk("r_rd0", 32'(bus.rdata0), 0);

      // simultaneous requests after reset: channel 0 first
      do_reset();
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 7; bus.wdata0 = 8'h33;
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8; bus.wdata1 = 8'h44;
      tick();
      chk("c_ma0", 32'(bus.mem_addr), 7);
      tick();
      chk("c_ack0", {30'd0, bus.ack1, bus.ack0}, 1);
      bus.req0 = 0;
      tick();
      chk("c_gap", 32'(bus.busy), 0);
      tick();
      chk("c_ma1", 32'(bus.mem_addr), 8);
      chk("c_md1", 32'(bus.mem_wdata), 32'h44);
      tick();
      chk("c_ack1", {30'd0, bus.ack1, bus.ack0}, 2);
      bus.req1 = 0;
      tick();

      // both held for four reads: strict alternation
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 7;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_busy", 32'(bus.busy), 1);
         chk("rr_ma", 32'(bus.mem_addr), (k % 2 == 0) ? 7 : 8);
         tick();
         chk("rr_ack", {30'd0, bus.ack1, bus.ack0},
             (k % 2 == 0) ? 1 : 2);
         if (k == 3) begin
            bus.req0 = 0;
            bus.req1 = 0;
         end
         tick();
         chk("rr_gap", 32'(bus.busy), 0);
      end
      chk("rr_rd0", 32'(bus.rdata0), 32'h33);
      chk("rr_rd1", 32'(bus.rdata1), 32'h44);

      // reset during a channel 1 write to addr 5
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 5; bus.wdata1 = 8'h55;
      tick();
      chk("a_mw_pre", 32'(bus.mem_write), 1);
      rst = 1'b1;
      #1;
      chk("a_mw_rst", 32'(bus.mem_write), 0);
      tick();
      chk("a_busy", 32'(bus.busy), 0);
      chk("a_ack", {30'd0, bus.ack1, bus.ack0}, 0);
      chk("a_ma", 32'(bus.mem_addr), 0);
      chk("a_rd0", 32'(bus.rdata0), 0);
      chk("a_rd1", 32'(bus.rdata1), 0);
      rst = 1'b0;
      bus.we1 = 0;
      tick();
      chk("a_rd_ma", 32'(bus.mem_addr), 5);
      tick();
      chk("a_rd_ack", 32'(bus.ack1), 1);
      bus.req1 = 0;
      tick();
      chk("a_rd_data", 32'(bus.rdata1), 32'h15);

      // address change mid-transaction is ignored
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 2;
      tick();
      bus.addr0 = 9;
      #1;
      chk("h_ma_acc", 32'(bus.mem_addr), 2);
      tick();
      chk("h_ma_done", 32'(bus.mem_addr), 2);
      chk("h_ack0", 32'(bus.ack0), 1);
      bus.req0 = 0;
      tick();
      chk("h_rd0", 32'(bus.rdata0), 32'h12);
      chk("h_rd1", 32'(bus.rdata1), 32'h15);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
